fm_mod: RTL
===========

Name: fm_mod

Overview:
- FM modulator: the transmit-side counterpart of the demod pipeline.
- Reads signed audio samples from an upstream FIFO and integrates them into a phase accumulator.
- Converts each phase to a unit-amplitude I/Q pair using an iterative CORDIC.
- Writes the pairs into the I and Q FIFOs that feed demod_top, or that feed the channel model in loopback benches.

Parameters:
DATA_WIDTH, 32, width of audio, I and Q data words
BITS, 10, fractional bits of Q-format samples (1.0 = 1024)
MOD_GAIN, 32'h0020_0000, phase increment per unit audio LSB; phase word 2^32 = 2π
ITER, 16, CORDIC iterations per sample

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
in_empty  in  1  audio FIFO empty
in_rd_en  out  1  audio FIFO pop; FIFO is first-word-fall-through
in_dout  in  DATA_WIDTH  signed audio sample, Q(BITS), valid while !in_empty
I_full  in  1  I FIFO full
I_wr_en  out  1  I FIFO write strobe
I_din  out  DATA_WIDTH  signed in-phase sample, Q(BITS)
Q_full  in  1  Q FIFO full
Q_wr_en  out  1  Q FIFO write strobe
Q_din  out  DATA_WIDTH  signed quadrature sample, Q(BITS)

Behaviour:
- Single clock domain. Reset is synchronous, active-low, and overrides everything.
- Values during and after reset:
  - state=S_IDLE, phase=0
  - in_rd_en=0, I_wr_en=0, Q_wr_en=0
  - I_din=0, Q_din=0
  - CORDIC registers=0
- S_IDLE:
  - in_rd_en = !in_empty (combinational).
  - On pop, register phase <= phase + (signed in_dout * MOD_GAIN), truncated mod 2^32; wrap-around is natural and intended.
  - Go to S_ROT.
- S_ROT (quadrant pre-rotation):
  - If phase[31:30] is 01 or 10, rotate by π and set a negate flag; otherwise the flag is cleared.
  - Load x=622 (0.60725·1024, CORDIC gain pre-compensated), y=0, z=reduced phase.
- S_ROT (iterations):
  - Perform ITER iterations, one per cycle. Iteration i: d=sign(z); x -= d·(y>>>i); y += d·(x>>>i); z -= d·atan_tab[i].
  - atan_tab holds atan(2^-i) in 2^32-per-turn units, as a constant table.
  - Shifts are arithmetic. Internal x/y carry 2 guard bits above DATA_WIDTH-equivalent range.
- S_ROT (result): after iteration ITER-1, apply the negate flag, sign-extend to DATA_WIDTH, register into I_din/Q_din, and go to S_WR.
- S_WR:
  - Hold I_din/Q_din stable.
  - When !I_full && !Q_full, assert I_wr_en and Q_wr_en together for exactly one cycle, then go to S_IDLE.
  - Never write one FIFO without the other.
- Ordering and throughput:
  - Output pair n uses the phase accumulated including sample n. The first sample 0 after reset gives I=+1024, Q=0.
  - Throughput is one sample per ITER+3 cycles minimum. Latency from pop to write strobe is ITER+2 cycles when the output FIFOs are not full.
- Flow control:
  - in_rd_en is never asserted outside S_IDLE. No sample is dropped or duplicated under any full/empty pattern.
  - Backpressure from either full flag stalls in S_WR indefinitely with outputs held.
- Reset mid-operation: an in-flight sample is discarded, phase returns to 0, and no partial write occurs.
- Accuracy: |I|,|Q| error ≤ 3 LSB versus ideal round(1024·cos/sin(phase)).

Test Plan:
- Reset: reset=0 for 3 cycles with in_empty=0, I_full=Q_full=0 -> in_rd_en, I_wr_en, Q_wr_en, I_din and Q_din all 0; first pop occurs the cycle after reset=1.
- Zero audio: four samples 0x00000000 -> four writes, each I=0x00000400±3, Q=0±3; write strobes spaced ≥ ITER+3 cycles.
- Positive step: four samples 0x00000200 (0.5, increment 2^30 = π/2) -> (I,Q) ≈ (0,1024), (-1024,0), (0,-1024), (1024,0); -1024 appears as 0xFFFFFC00±3; the 4th pair confirms phase wrap.
- Negative sample: one 0xFFFFFE00 from reset -> I≈0, Q≈0xFFFFFC00 (±3).
- Backpressure:
  - Hold I_full=1, Q_full=0 for 20 cycles during S_WR -> no wr_en on either FIFO and in_rd_en=0.
  - Release I_full -> exactly one simultaneous I/Q write with unchanged data.
  - Repeat with Q_full.
- Random and reset stress:
  - 1000 random audio samples in ±0.5 with random full/empty gaps, checked against the software model -> count and order preserved, all errors ≤3 LSB.
  - Assert reset mid-S_ROT -> no write for that sample; the next sample's output uses phase from 0.

Source files
------------

// File: rtl/fm_mod.sv
// FM modulator: integrates signed audio into a 32-bit phase word and turns
// each phase into a unit-amplitude I/Q pair with an iterative CORDIC rotator.
module fm_mod #(
  parameter int          DATA_WIDTH = 32,
  parameter int          BITS       = 10,
  parameter logic [31:0] MOD_GAIN   = 32'h0020_0000,
  parameter int          ITER       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  I_full,
  output logic                  I_wr_en,
  output logic [DATA_WIDTH-1:0] I_din,
  input  logic                  Q_full,
  output logic                  Q_wr_en,
  output logic [DATA_WIDTH-1:0] Q_din
);

  // x/y carry two integer guard bits plus a few fractional bits so the
  // truncating arithmetic shifts do not accumulate a visible bias.
  localparam int FRAC = 4;
  localparam int XW   = DATA_WIDTH + 2 + FRAC;
  localparam int CW   = $clog2(ITER + 1);
  // 0.60725 * 2^BITS: start vector pre-scaled by the inverse CORDIC gain.
  localparam longint X_UNIT = (64'sd607253 * (64'sd1 <<< BITS) + 64'sd500000) / 64'sd1000000;
  localparam logic signed [XW-1:0] X_INIT = XW'(X_UNIT * (2 ** FRAC));
  localparam logic signed [XW-1:0] X_HALF = XW'(2 ** (FRAC - 1));

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_WR} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             phase_q, phase_d;
  logic [31:0]             audio_w, phase_inc;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d, x_it, y_it;
  logic signed [31:0]      z_q, z_d, z_it;
  logic                    neg_q, neg_d;
  logic [CW-1:0]           cnt_q, cnt_d, sh;
  logic [DATA_WIDTH-1:0]   i_din_q, i_din_d, q_din_q, q_din_d;
  logic signed [DATA_WIDTH-1:0] i_rnd, q_rnd;

  // atan(2^-i) with one full turn = 2^32; small angles fall back to atan(x)~x.
  function automatic logic [31:0] atan_lut(input logic [CW-1:0] idx);
    int unsigned k;
    k = idx;
    case (k)
      0:       atan_lut = 32'h2000_0000;
      1:       atan_lut = 32'h12E4_051E;
      2:       atan_lut = 32'h09FB_385B;
      3:       atan_lut = 32'h0511_11D4;
      4:       atan_lut = 32'h028B_0D43;
      5:       atan_lut = 32'h0145_D7E1;
      6:       atan_lut = 32'h00A2_F61E;
      7:       atan_lut = 32'h0051_7C55;
      8:       atan_lut = 32'h0028_BE53;
      9:       atan_lut = 32'h0014_5F2F;
      10:      atan_lut = 32'h000A_2F98;
      11:      atan_lut = 32'h0005_17CC;
      12:      atan_lut = 32'h0002_8BE6;
      13:      atan_lut = 32'h0001_45F3;
      14:      atan_lut = 32'h0000_A2FA;
      15:      atan_lut = 32'h0000_517D;
      default: atan_lut = 32'(64'd683565276 >> k);
    endcase
  endfunction

  // Phase increment is only needed mod 2^32, so the low product bits suffice.
  assign audio_w   = 32'($signed(in_dout));
  assign phase_inc = audio_w * MOD_GAIN;

  assign I_din = i_din_q;
  assign Q_din = q_din_q;

  // One CORDIC micro-rotation (iteration index cnt_q-1) plus output rounding.
  always_comb begin
    sh = cnt_q - CW'(1);
    if (!z_q[31]) begin
      x_it = x_q - (y_q >>> sh);
      y_it = y_q + (x_q >>> sh);
      z_it = z_q - $signed(atan_lut(sh));
    end else begin
      x_it = x_q + (y_q >>> sh);
      y_it = y_q - (x_q >>> sh);
      z_it = z_q + $signed(atan_lut(sh));
    end
    i_rnd = DATA_WIDTH'((x_it + X_HALF) >>> FRAC);
    q_rnd = DATA_WIDTH'((y_it + X_HALF) >>> FRAC);
  end

  // Next-state and FIFO handshake logic; strobes are suppressed during reset.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    i_din_d  = i_din_q;
    q_din_d  = q_din_q;
    in_rd_en = 1'b0;
    I_wr_en  = 1'b0;
    Q_wr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          phase_d  = phase_q + phase_inc;
          cnt_d    = '0;
          state_d  = S_ROT;
        end
      end
      S_ROT: begin
        if (cnt_q == '0) begin
          // Quadrants 1 and 2 are folded by pi into CORDIC's convergence range.
          neg_d = phase_q[31] ^ phase_q[30];
          z_d   = $signed(phase_q + ((phase_q[31] ^ phase_q[30]) ? 32'h8000_0000 : 32'h0));
          x_d   = X_INIT;
          y_d   = '0;
          cnt_d = CW'(1);
        end else begin
          x_d = x_it;
          y_d = y_it;
          z_d = z_it;
          if (cnt_q == CW'(ITER)) begin
            i_din_d = neg_q ? -i_rnd : i_rnd;
            q_din_d = neg_q ? -q_rnd : q_rnd;
            state_d = S_WR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WR: begin
        if (!I_full && !Q_full) begin
          I_wr_en = 1'b1;
          Q_wr_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      in_rd_en = 1'b0;
      I_wr_en  = 1'b0;
      Q_wr_en  = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      i_din_q <= '0;
      q_din_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      i_din_q <= i_din_d;
      q_din_q <= q_din_d;
    end
  end

endmodule
